// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions for the register responder.
//   resp_t      : response codes this slave can return (OKAY / SLVERR)
//   AXIL_DATA_W : bus data width (fixed at 32)
//   AXIL_STRB_W : byte-enable width
//   strb_merge  : byte-lane merge of a new word into an old one
package axil_pkg;

    localparam int AXIL_DATA_W = 32;
    localparam int AXIL_STRB_W = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        SLVERR = 2'b10
    } resp_t;

    function automatic logic [AXIL_DATA_W-1:0] strb_merge(
        input logic [AXIL_DATA_W-1:0] old_word,
        input logic [AXIL_DATA_W-1:0] new_word,
        input logic [AXIL_STRB_W-1:0] strb
    );
        logic [AXIL_DATA_W-1:0] merged;
        merged = old_word;
        for (int b = 0; b < AXIL_STRB_W; b++) begin
            if (strb[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/axil_reg_responder_if.sv
// AXI4-Lite bus bundle between a master and the register responder.
//   slave modport  : responder side (AW/W/AR payload+valid in, readies and B/R out)
//   master modport : requester side (mirror of slave)
interface axil_reg_responder_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);

    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;

    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;

    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;

    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;

    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );

endinterface

// File: rtl/axil_wr_join.sv
// Joins the independent AW and W channels into one write-commit strobe.
// Either beat may arrive first; it is parked in a hold register until its
// partner shows up. The commit fires on the first edge where both are
// available (held or handshaking in that cycle).
//   clk_i, rst_i        : clock, async active-high reset
//   awaddr_i/awvalid_i  : write address channel in, awready_o out
//   wdata_i/wstrb_i/wvalid_i : write data channel in, wready_o out
//   resp_busy_i         : a write response is outstanding; accept nothing
//   commit_o + commit_addr_o/commit_data_o/commit_strb_o : joined write
module axil_wr_join
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [ADDR_WIDTH-1:0]  awaddr_i,
    input  logic                   awvalid_i,
    output logic                   awready_o,
    input  logic [AXIL_DATA_W-1:0] wdata_i,
    input  logic [AXIL_STRB_W-1:0] wstrb_i,
    input  logic                   wvalid_i,
    output logic                   wready_o,
    input  logic                   resp_busy_i,
    output logic                   commit_o,
    output logic [ADDR_WIDTH-1:0]  commit_addr_o,
    output logic [AXIL_DATA_W-1:0] commit_data_o,
    output logic [AXIL_STRB_W-1:0] commit_strb_o
);

    logic                   aw_hold_q, aw_hold_d;
    logic [ADDR_WIDTH-1:0]  aw_addr_q, aw_addr_d;
    logic                   w_hold_q, w_hold_d;
    logic [AXIL_DATA_W-1:0] w_data_q, w_data_d;
    logic [AXIL_STRB_W-1:0] w_strb_q, w_strb_d;
    logic                   aw_fire, w_fire;

    // Readies are forced low during reset so nothing is accepted then.
    assign awready_o = !rst_i && !aw_hold_q && !resp_busy_i;
    assign wready_o  = !rst_i && !w_hold_q  && !resp_busy_i;
    assign aw_fire   = awvalid_i && awready_o;
    assign w_fire    = wvalid_i  && wready_o;

    assign commit_o      = (aw_hold_q || aw_fire) && (w_hold_q || w_fire);
    assign commit_addr_o = aw_hold_q ? aw_addr_q : awaddr_i;
    assign commit_data_o = w_hold_q  ? w_data_q  : wdata_i;
    assign commit_strb_o = w_hold_q  ? w_strb_q  : wstrb_i;

    always_comb begin
        aw_hold_d = aw_hold_q;
        aw_addr_d = aw_addr_q;
        w_hold_d  = w_hold_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        if (commit_o) begin
            aw_hold_d = 1'b0;
            w_hold_d  = 1'b0;
        end else begin
            if (aw_fire) begin
                aw_hold_d = 1'b1;
                aw_addr_d = awaddr_i;
            end
            if (w_fire) begin
                w_hold_d = 1'b1;
                w_data_d = wdata_i;
                w_strb_d = wstrb_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            aw_hold_q <= 1'b0;
            aw_addr_q <= '0;
            w_hold_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
        end else begin
            aw_hold_q <= aw_hold_d;
            aw_addr_q <= aw_addr_d;
            w_hold_q  <= w_hold_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
        end
    end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite slave register bank: NUM_REGS 32-bit read/write registers.
// Single-beat accesses only, at most one write and one read outstanding.
//   S_AXI_ACLK, S_AXI_ARESET : clock, async active-high reset
//   bus        : AXI4-Lite slave channels (AW, W, B, AR, R)
//   regs_o     : flat register contents, reg k at [32k+31:32k]
//   wr_pulse_o : bit k high for one cycle after reg k is written
// Only DATA_WIDTH = 32 is supported.
module axil_reg_responder
    import axil_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_REGS   = 4
) (
    input  logic                           S_AXI_ACLK,
    input  logic                           S_AXI_ARESET,
    axil_reg_responder_if.slave            bus,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o
);

    localparam int IDX_W = ADDR_WIDTH - 2;

    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
    logic [NUM_REGS-1:0]    wr_pulse_q, wr_pulse_d;
    logic                   bvalid_q, bvalid_d;
    resp_t                  bresp_q, bresp_d;
    logic                   rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    resp_t                  rresp_q, rresp_d;

    logic                   commit;
    logic [ADDR_WIDTH-1:0]  commit_addr;
    logic [AXIL_DATA_W-1:0] commit_data;
    logic [AXIL_STRB_W-1:0] commit_strb;

    logic [IDX_W-1:0]       wr_idx, rd_idx;
    logic                   wr_in_range, rd_in_range;
    logic [DATA_WIDTH-1:0]  rd_word;
    logic                   arready, ar_fire;

    axil_wr_join #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_wr_join (
        .clk_i         (S_AXI_ACLK),
        .rst_i         (S_AXI_ARESET),
        .awaddr_i      (bus.S_AXI_AWADDR),
        .awvalid_i     (bus.S_AXI_AWVALID),
        .awready_o     (bus.S_AXI_AWREADY),
        .wdata_i       (bus.S_AXI_WDATA),
        .wstrb_i       (bus.S_AXI_WSTRB),
        .wvalid_i      (bus.S_AXI_WVALID),
        .wready_o      (bus.S_AXI_WREADY),
        .resp_busy_i   (bvalid_q),
        .commit_o      (commit),
        .commit_addr_o (commit_addr),
        .commit_data_o (commit_data),
        .commit_strb_o (commit_strb)
    );

    // Byte offset bits and PROT are don't-care for a word-wide register bank.
    logic unused_ok;
    assign unused_ok = ^{bus.S_AXI_AWPROT, bus.S_AXI_ARPROT,
                         bus.S_AXI_ARADDR[1:0], commit_addr[1:0]};

    assign wr_idx      = commit_addr[ADDR_WIDTH-1:2];
    assign rd_idx      = bus.S_AXI_ARADDR[ADDR_WIDTH-1:2];
    assign wr_in_range = {1'b0, wr_idx} < (IDX_W+1)'(NUM_REGS);
    assign rd_in_range = {1'b0, rd_idx} < (IDX_W+1)'(NUM_REGS);

    // Write side: commit updates the target register and raises BVALID.
    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        if (commit) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_in_range ? OKAY : SLVERR;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (wr_in_range && (wr_idx == IDX_W'(k))) begin
                    regs_d[k]     = strb_merge(regs_q[k], commit_data, commit_strb);
                    wr_pulse_d[k] = 1'b1;
                end
            end
        end else if (bvalid_q && bus.S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
    end

    // Read side samples regs_q, so a same-cycle write is not yet visible.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    assign arready = !S_AXI_ARESET && !rvalid_q;
    assign ar_fire = bus.S_AXI_ARVALID && arready;

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_in_range ? rd_word : '0;
            rresp_d  = rd_in_range ? OKAY : SLVERR;
        end else if (rvalid_q && bus.S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                regs_q[k] <= '0;
            end
            wr_pulse_q <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= OKAY;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    always_comb begin
        regs_o = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            regs_o[k*DATA_WIDTH +: DATA_WIDTH] = regs_q[k];
        end
    end

    assign wr_pulse_o        = wr_pulse_q;
    assign bus.S_AXI_BVALID  = bvalid_q;
    assign bus.S_AXI_BRESP   = bresp_q;
    assign bus.S_AXI_ARREADY = arready;
    assign bus.S_AXI_RVALID  = rvalid_q;
    assign bus.S_AXI_RDATA   = rdata_q;
    assign bus.S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_axil_reg_responder.sv
module tb_axil_reg_responder;

    localparam int AW = 5;
    localparam int NR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axil_reg_responder_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) bus ();

    logic [NR*32-1:0] regs_o;
    logic [NR-1:0]    wr_pulse_o;

    axil_reg_responder #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .S_AXI_ACLK   (clk),
        .S_AXI_ARESET (rst),
        .bus          (bus),
        .regs_o       (regs_o),
        .wr_pulse_o   (wr_pulse_o)
    );

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] model [NR];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [127:0] model_flat();
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < NR; k++) r[32*k +: 32] = model[k];
        return r;
    endfunction

    function automatic void model_clear();
        for (int k = 0; k < NR; k++) model[k] = 32'h0;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d,
                                        input logic [3:0] s, output logic [1:0] resp,
                                        output logic [3:0] pulse);
        int idx;
        idx = int'(a) / 4;
        pulse = 4'h0;
        if (idx < NR) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
            resp = 2'b00;
            pulse[idx] = 1'b1;
        end else begin
            resp = 2'b10;
        end
    endfunction

    function automatic void model_read(input logic [AW-1:0] a, output logic [31:0] d,
                                       output logic [1:0] resp);
        int idx;
        idx = int'(a) / 4;
        if (idx < NR) begin
            d = model[idx];
            resp = 2'b00;
        end else begin
            d = 32'h0;
            resp = 2'b10;
        end
    endfunction

    // ---------------- bus tasks ----------------
    task automatic do_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] exp_resp;
        logic [3:0] exp_pulse;
        bit aw_done, w_done, aw_hs, w_hs, got_b;
        int cyc;
        aw_done = 0; w_done = 0; got_b = 0; cyc = 0;
        model_write(a, d, s, exp_resp, exp_pulse);
        @(negedge clk);
        while (!(aw_done && w_done) && cyc < 40) begin
            bus.S_AXI_AWVALID = !aw_done && (cyc >= aw_dly);
            bus.S_AXI_AWADDR  = a;
            bus.S_AXI_AWPROT  = 3'($urandom);
            bus.S_AXI_WVALID  = !w_done && (cyc >= w_dly);
            bus.S_AXI_WDATA   = d;
            bus.S_AXI_WSTRB   = s;
            #1;
            if (bus.S_AXI_AWVALID) check("awready", bus.S_AXI_AWREADY, 1);
            if (bus.S_AXI_WVALID)  check("wready", bus.S_AXI_WREADY, 1);
            if (aw_done && !w_done) check("awready_held", bus.S_AXI_AWREADY, 0);
            if (w_done && !aw_done) check("wready_held", bus.S_AXI_WREADY, 0);
            aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
            w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
            @(posedge clk);
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
            @(negedge clk);
        end
        bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WVALID  = 1'b0;
        if (!(aw_done && w_done)) check("wr_accept_timeout", 0, 1);
        check("bvalid_lat", bus.S_AXI_BVALID, 1);
        check("regs_after_wr", regs_o, model_flat());
        check("wr_pulse", wr_pulse_o, exp_pulse);
        cyc = 0;
        while (!got_b && cyc < 40) begin
            bus.S_AXI_BREADY = (cyc >= b_dly);
            #1;
            if (bus.S_AXI_BVALID && bus.S_AXI_BREADY) begin
                check("bresp", bus.S_AXI_BRESP, exp_resp);
                got_b = 1;
            end else if (bus.S_AXI_BVALID) begin
                check("bp_awready", bus.S_AXI_AWREADY, 0);
                check("bp_wready", bus.S_AXI_WREADY, 0);
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        bus.S_AXI_BREADY = 1'b0;
        if (!got_b) check("b_timeout", 0, 1);
        check("bvalid_clr", bus.S_AXI_BVALID, 0);
        check("wr_pulse_clr", wr_pulse_o, 0);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int r_dly);
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        model_read(a, exp_d, exp_r);
        @(negedge clk);
        bus.S_AXI_ARADDR  = a;
        bus.S_AXI_ARPROT  = 3'($urandom);
        bus.S_AXI_ARVALID = 1'b1;
        bus.S_AXI_RREADY  = 1'b0;
        #1 check("arready", bus.S_AXI_ARREADY, 1);
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_ARVALID = 1'b0;
        check("rvalid_lat", bus.S_AXI_RVALID, 1);
        check("rdata", bus.S_AXI_RDATA, exp_d);
        check("rresp", bus.S_AXI_RRESP, exp_r);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rvalid_hold", bus.S_AXI_RVALID, 1);
            check("rdata_stable", bus.S_AXI_RDATA, exp_d);
            check("arready_blocked", bus.S_AXI_ARREADY, 0);
        end
        bus.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_RREADY = 1'b0;
        check("rvalid_clr", bus.S_AXI_RVALID, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] old_v, new_v;
        logic [1:0]  er;
        logic [3:0]  ep;

        bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
        bus.S_AXI_WDATA  = '0; bus.S_AXI_WSTRB  = '0; bus.S_AXI_WVALID  = 1'b0;
        bus.S_AXI_BREADY = 1'b0;
        bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
        bus.S_AXI_RREADY = 1'b0;
        model_clear();

        repeat (3) @(negedge clk);
        check("rst_awready", bus.S_AXI_AWREADY, 0);
        check("rst_wready", bus.S_AXI_WREADY, 0);
        check("rst_arready", bus.S_AXI_ARREADY, 0);
        check("rst_bvalid", bus.S_AXI_BVALID, 0);
        check("rst_rvalid", bus.S_AXI_RVALID, 0);
        check("rst_rdata", bus.S_AXI_RDATA, 0);
        check("rst_regs", regs_o, 0);
        check("rst_pulse", wr_pulse_o, 0);
        rst = 1'b0;
        #1;
        check("post_rst_awready", bus.S_AXI_AWREADY, 1);
        check("post_rst_arready", bus.S_AXI_ARREADY, 1);

        // sequential write then read-back
        for (int k = 0; k < NR; k++) do_write(AW'(4*k), 32'(k+1), 4'hF, 0, 0, 0);
        for (int k = 0; k < NR; k++) do_read(AW'(4*k), 0);

        // partial strobe: expect 0x11BB33DD
        do_write(5'h04, 32'h11223344, 4'hF, 0, 0, 0);
        do_write(5'h04, 32'hAABBCCDD, 4'b0101, 0, 0, 0);
        check("partial_model", model[1], 32'h11BB33DD);
        do_read(5'h04, 0);

        // channel skew both ways
        do_write(5'h08, 32'hCAFE0008, 4'hF, 0, 3, 0);
        do_write(5'h0C, 32'hBEEF000C, 4'hF, 3, 0, 0);
        do_read(5'h08, 0);
        do_read(5'h0C, 0);

        // back-pressure on B and R
        do_write(5'h00, 32'h5A5A5A5A, 4'hF, 0, 0, 5);
        do_read(5'h00, 4);

        // out of range, low addr bits ignored
        do_write(5'h10, 32'h0000DEAD, 4'hF, 0, 0, 0);
        do_read(5'h14, 0);
        do_read(5'h0B, 1);

        // same-cycle read and write of one register: read sees old value
        @(negedge clk);
        old_v = model[2];
        new_v = $urandom;
        bus.S_AXI_AWADDR = 5'h08; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = new_v;  bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        bus.S_AXI_ARADDR = 5'h08; bus.S_AXI_ARVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
        model_write(5'h08, new_v, 4'hF, er, ep);
        check("rw_rvalid", bus.S_AXI_RVALID, 1);
        check("rw_bvalid", bus.S_AXI_BVALID, 1);
        check("rw_rdata_old", bus.S_AXI_RDATA, old_v);
        check("rw_regs", regs_o, model_flat());
        bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
        check("rw_bclr", bus.S_AXI_BVALID, 0);
        check("rw_rclr", bus.S_AXI_RVALID, 0);

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(1, 0) == 1)
                do_write(AW'($urandom), $urandom, 4'($urandom),
                         $urandom_range(3, 0), $urandom_range(3, 0), $urandom_range(3, 0));
            else
                do_read(AW'($urandom), $urandom_range(2, 0));
        end

        // reset while a write response is pending
        @(negedge clk);
        bus.S_AXI_AWADDR = 5'h04; bus.S_AXI_AWVALID = 1'b1;
        bus.S_AXI_WDATA = 32'h12345678; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
        check("pre_rst_bvalid", bus.S_AXI_BVALID, 1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_bvalid", bus.S_AXI_BVALID, 0);
        check("mid_rst_regs", regs_o, 0);
        check("mid_rst_awready", bus.S_AXI_AWREADY, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        do_write(5'h04, 32'h0BADF00D, 4'hF, 1, 0, 0);
        do_read(5'h04, 0);
        do_read(5'h00, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
